// File: rtl/fir_pkg.sv
// Shared constants, types and low-pass coefficient set for the three-parallel FIR.
// Coefficients are a symmetric triangular low-pass kernel (linear phase, DC gain 769080).
package fir_pkg;

    localparam int NTAPS      = 102;
    localparam int DW         = 16;
    localparam int OW         = 64;
    localparam int NPHASE     = 3;
    localparam int PHASE_TAPS = NTAPS / NPHASE;
    localparam int LAT        = 3;

    typedef logic signed [DW-1:0]   sample_t;
    typedef logic signed [DW-1:0]   coef_t;
    typedef logic signed [2*DW-1:0] prod_t;
    typedef logic signed [OW-1:0]   acc_t;

    localparam coef_t COEFFS [NTAPS] = '{
        16'sd40,    16'sd340,   16'sd640,   16'sd940,   16'sd1240,  16'sd1540,
        16'sd1840,  16'sd2140,  16'sd2440,  16'sd2740,  16'sd3040,  16'sd3340,
        16'sd3640,  16'sd3940,  16'sd4240,  16'sd4540,  16'sd4840,  16'sd5140,
        16'sd5440,  16'sd5740,  16'sd6040,  16'sd6340,  16'sd6640,  16'sd6940,
        16'sd7240,  16'sd7540,  16'sd7840,  16'sd8140,  16'sd8440,  16'sd8740,
        16'sd9040,  16'sd9340,  16'sd9640,  16'sd9940,  16'sd10240, 16'sd10540,
        16'sd10840, 16'sd11140, 16'sd11440, 16'sd11740, 16'sd12040, 16'sd12340,
        16'sd12640, 16'sd12940, 16'sd13240, 16'sd13540, 16'sd13840, 16'sd14140,
        16'sd14440, 16'sd14740, 16'sd15040,
        16'sd15040, 16'sd14740, 16'sd14440,
        16'sd14140, 16'sd13840, 16'sd13540, 16'sd13240, 16'sd12940, 16'sd12640,
        16'sd12340, 16'sd12040, 16'sd11740, 16'sd11440, 16'sd11140, 16'sd10840,
        16'sd10540, 16'sd10240, 16'sd9940,  16'sd9640,  16'sd9340,  16'sd9040,
        16'sd8740,  16'sd8440,  16'sd8140,  16'sd7840,  16'sd7540,  16'sd7240,
        16'sd6940,  16'sd6640,  16'sd6340,  16'sd6040,  16'sd5740,  16'sd5440,
        16'sd5140,  16'sd4840,  16'sd4540,  16'sd4240,  16'sd3940,  16'sd3640,
        16'sd3340,  16'sd3040,  16'sd2740,  16'sd2440,  16'sd2140,  16'sd1840,
        16'sd1540,  16'sd1240,  16'sd940,   16'sd640,   16'sd340,   16'sd40
    };

    // Tap idx of polyphase branch phase: h_phase[idx] = h[3*idx + phase].
    function automatic coef_t phase_coef(input int phase, input int idx);
        return COEFFS[NPHASE*idx + phase];
    endfunction

endpackage

// File: rtl/fir_subfilter.sv
// One polyphase branch: PHASE_TAPS-tap direct-form FIR on block-rate samples.
// Latency 2 cycles (product register, accumulator register); no backpressure.
module fir_subfilter
    import fir_pkg::*;
#(
    parameter int PHASE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [15:0]   x_i,
    output logic signed [63:0]   y_o
);

    sample_t hist_q [PHASE_TAPS-1];
    prod_t   prod_q [PHASE_TAPS];
    sample_t tap_w  [PHASE_TAPS];
    coef_t   coef_w [PHASE_TAPS];
    acc_t    acc_d;
    acc_t    acc_q;

    for (genvar g = 0; g < PHASE_TAPS; g++) begin : g_coef
        assign coef_w[g] = phase_coef(PHASE, g);
    end

    always_comb begin
        tap_w[0] = x_i;
        for (int i = 1; i < PHASE_TAPS; i++) begin
            tap_w[i] = hist_q[i-1];
        end
    end

    always_comb begin
        acc_d = '0;
        for (int i = 0; i < PHASE_TAPS; i++) begin
            acc_d = acc_d + acc_t'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHASE_TAPS-1; i++) hist_q[i] <= '0;
            for (int i = 0; i < PHASE_TAPS; i++)   prod_q[i] <= '0;
            acc_q <= '0;
        end else begin
            hist_q[0] <= x_i;
            for (int i = 1; i < PHASE_TAPS-1; i++) hist_q[i] <= hist_q[i-1];
            for (int i = 0; i < PHASE_TAPS; i++) begin
                prod_q[i] <= prod_t'(tap_w[i]) * prod_t'(coef_w[i]);
            end
            acc_q <= acc_d;
        end
    end

    assign y_o = acc_q;

endmodule

// File: rtl/top.sv
// Three-parallel polyphase low-pass FIR: three samples in, three full-precision outputs per clock.
// Latency 3 cycles after the sampling edge; free-running, no backpressure or stalls.
module top
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [15:0]   din0,
    input  logic signed [15:0]   din1,
    input  logic signed [15:0]   din2,
    output logic signed [63:0]   dout0,
    output logic signed [63:0]   dout1,
    output logic signed [63:0]   dout2
);

    sample_t x_q [NPHASE];
    // acc_w[input][phase] holds H_phase applied to input stream X_input.
    acc_t    acc_w [NPHASE][NPHASE];
    acc_t    cross0_d, cross0_q;
    acc_t    cross1_d, cross1_q;
    acc_t    y0_d, y0_q;
    acc_t    y1_d, y1_q;
    acc_t    y2_d, y2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHASE; i++) x_q[i] <= '0;
        end else begin
            x_q[0] <= din0;
            x_q[1] <= din1;
            x_q[2] <= din2;
        end
    end

    for (genvar gi = 0; gi < NPHASE; gi++) begin : g_in
        for (genvar gp = 0; gp < NPHASE; gp++) begin : g_ph
            fir_subfilter #(
                .PHASE (gp)
            ) u_sub (
                .clk (clk),
                .rst (rst),
                .x_i (x_q[gi]),
                .y_o (acc_w[gi][gp])
            );
        end
    end

    // Cross terms are registered one block early so they line up as z^-1 at the output adder.
    always_comb begin
        cross0_d = acc_w[2][1] + acc_w[1][2];
        cross1_d = acc_w[2][2];
        y0_d     = acc_w[0][0] + cross0_q;
        y1_d     = acc_w[1][0] + acc_w[0][1] + cross1_q;
        y2_d     = acc_w[2][0] + acc_w[1][1] + acc_w[0][2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cross0_q <= '0;
            cross1_q <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
        end else begin
            cross0_q <= cross0_d;
            cross1_q <= cross1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            y2_q     <= y2_d;
        end
    end

    assign dout0 = y0_q;
    assign dout1 = y1_q;
    assign dout2 = y2_q;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the three-parallel FIR against a serial convolution model.
module tb_top;
    import fir_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] din0, din1, din2;
    logic signed [63:0] dout0, dout1, dout2;

    always #5 clk = ~clk;

    top dut (
        .clk   (clk),
        .rst   (rst),
        .din0  (din0),
        .din1  (din1),
        .din2  (din2),
        .dout0 (dout0),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    typedef struct {
        int     due;
        longint y0;
        longint y1;
        longint y2;
    } exp_t;

    exp_t sbq [$];
    int   hist [$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic longint yref(input int n);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (n - k >= 0) acc += longint'(COEFFS[k]) * longint'(hist[n-k]);
        end
        return acc;
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    // Issue one block; its response is due on the fourth falling edge from now.
    task automatic drive(input int a, input int b, input int c, input bit r);
        exp_t e;
        int   last;
        @(negedge clk);
        rst  = r;
        din0 = 16'(a);
        din1 = 16'(b);
        din2 = 16'(c);
        e.due = cyc + 4;
        if (r) begin
            hist.delete();
            foreach (sbq[i]) begin
                if (sbq[i].due > cyc) begin
                    sbq[i].y0 = 0;
                    sbq[i].y1 = 0;
                    sbq[i].y2 = 0;
                end
            end
            last = (sbq.size() > 0) ? sbq[$].due : cyc;
            for (int d = last + 1; d <= cyc + 3; d++) begin
                sbq.push_back('{due: d, y0: 0, y1: 0, y2: 0});
            end
            e.y0 = 0;
            e.y1 = 0;
            e.y2 = 0;
        end else begin
            hist.push_back(a);
            hist.push_back(b);
            hist.push_back(c);
            e.y0 = yref(hist.size() - 3);
            e.y1 = yref(hist.size() - 2);
            e.y2 = yref(hist.size() - 1);
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("sb_dout0", dout0, e.y0);
            chk("sb_dout1", dout1, e.y1);
            chk("sb_dout2", dout2, e.y2);
        end
    end

    initial begin
        rst  = 1'b1;
        din0 = 16'sd1234;
        din1 = 16'sd1234;
        din2 = 16'sd1234;

        drive(1234, 1234, 1234, 1'b1);
        drive(1234, 1234, 1234, 1'b1);
        repeat (6) drive(0, 0, 0, 1'b0);

        drive(1, 0, 0, 1'b0);
        repeat (40) drive(0, 0, 0, 1'b0);

        drive(0, 0, 1, 1'b0);
        repeat (4) drive(0, 0, 0, 1'b0);
        chk("imp2_b3_dout0", dout0, 0);
        chk("imp2_b3_dout1", dout1, 0);
        chk("imp2_b3_dout2", dout2, 40);
        drive(0, 0, 0, 1'b0);
        chk("imp2_b4_dout0", dout0, 340);
        chk("imp2_b4_dout1", dout1, 640);
        chk("imp2_b4_dout2", dout2, 940);
        repeat (36) drive(0, 0, 0, 1'b0);

        repeat (40) drive(32767, 32767, 32767, 1'b0);
        chk("dc_pos_dout0", dout0, 64'sd25200444360);
        chk("dc_pos_dout1", dout1, 64'sd25200444360);
        chk("dc_pos_dout2", dout2, 64'sd25200444360);
        repeat (40) drive(-32768, -32768, -32768, 1'b0);
        chk("dc_neg_dout0", dout0, -64'sd25201213440);
        chk("dc_neg_dout1", dout1, -64'sd25201213440);
        chk("dc_neg_dout2", dout2, -64'sd25201213440);

        repeat (500) drive(rnd16(), rnd16(), rnd16(), 1'b0);
        drive(0, 0, 0, 1'b1);
        drive(0, 1, 0, 1'b0);
        repeat (4) drive(0, 0, 0, 1'b0);
        chk("fresh_imp1_dout0", dout0, 0);
        chk("fresh_imp1_dout1", dout1, 40);
        chk("fresh_imp1_dout2", dout2, 340);
        repeat (2834) drive(rnd16(), rnd16(), rnd16(), 1'b0);
        repeat (4) drive(0, 0, 0, 1'b0);

        repeat (6) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
